// File: rtl/rv32_pipe_pkg.sv
// Shared types and constants for the RV32I 5-stage pipeline control slice.
package rv32_pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0]  REG_X0   = 5'd0;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use hazard detector: the ID instruction reads a register the load in EX is about to write.
module load_use_detect
  import rv32_pipe_pkg::*;
(
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] rd_ex,
  input  logic       mem_read_ex,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = mem_read_ex && (rd_ex != REG_X0) &&
                    ((use_rs1_id && (rs1_id == rd_ex)) ||
                     (use_rs2_id && (rs2_id == rd_ex)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the RV32I pipeline: mem wait > taken branch > load-use.
// Optional perf counters built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        use_rs1_ID,
  input  logic        use_rs2_ID,
  input  logic [4:0]  rd_EX,
  input  logic        mem_read_EX,
  input  logic        PCSel_EX,
  input  logic        dmem_req_MEM,
  input  logic        dmem_ready,
  output logic        stall_PC,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEM,
  output logic        flush_ID,
  output logic        flush_EX,
  output logic        flush_WB,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  hz_state_e  state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       load_use;
  logic       mem_wait;

  load_use_detect u_load_use (
    .rs1_id      (rs1_ID),
    .rs2_id      (rs2_ID),
    .use_rs1_id  (use_rs1_ID),
    .use_rs2_id  (use_rs2_ID),
    .rd_ex       (rd_EX),
    .mem_read_ex (mem_read_EX),
    .load_use    (load_use)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (dmem_req_MEM && !dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // The timeout cycle itself does not stall, so the aborted access drains normally.
  assign mem_wait = ((state_q == RUN) && dmem_req_MEM && !dmem_ready) ||
                    ((state_q == MEM_WAIT) && !dmem_ready && (wait_cnt_q != TIMEOUT_CNT));

  // Gating with rst makes the controls drop as soon as reset asserts, without waiting for an edge.
  always_comb begin
    stall_PC  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    flush_WB  = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        stall_PC  = 1'b1;
        stall_ID  = 1'b1;
        stall_EX  = 1'b1;
        stall_MEM = 1'b1;
        flush_WB  = 1'b1;
      end else if (PCSel_EX) begin
        flush_ID = 1'b1;
        flush_EX = 1'b1;
      end else if (load_use) begin
        stall_PC = 1'b1;
        stall_ID = 1'b1;
        flush_EX = 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_PC && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (PCSel_EX && flush_EX && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
